mvm_input_feeder: RTL
=====================

# mvm_input_feeder

Host-side counterpart of the MVM controller's input/output handshake. It launches a job with a `start` pulse and answers every `input_req` by fetching the next operand from operand memory, then presenting it with a one-cycle `input_ready`. It captures each `output_valid` result into result memory and reports job completion when the controller pulses `done`. It sits between the host/memory subsystem and the MVM controller/PE array.

## Interface
- `INPUT_WIDTH`, default `` `INPUT_WIDTH ``: elements per row, the controller's width_index range.
- `INPUT_HEIGHT`, default `` `INPUT_HEIGHT ``: rows, the controller's height_index range.
- `DATA_WIDTH`, default 8: operand width.
- `SUM_WIDTH`, default 16: partial-sum width.
- `ADDR_WIDTH`, default `$clog2(INPUT_WIDTH*INPUT_HEIGHT)`: memory address width.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `cmd_valid` in 1: host requests a job.
- `cmd_ready` out 1: feeder idle and can accept a job.
- `start` out 1: one-cycle job launch to the controller.
- `input_req` in 1: controller wants the next operand.
- `input_ready` out 1: operand valid, one-cycle pulse.
- `operand` out DATA_WIDTH: operand to the PEs; held until the next capture.
- `rd_en` out 1: operand-memory read strobe.
- `rd_addr` out ADDR_WIDTH: read address.
- `rd_data` in DATA_WIDTH: read data, valid exactly 1 cycle after `rd_en`.
- `output_valid` in 1: controller result strobe.
- `partial_sum` in SUM_WIDTH: result accompanying `output_valid`.
- `wr_en` out 1: result-memory write strobe.
- `wr_addr` out ADDR_WIDTH: write address.
- `wr_data` out SUM_WIDTH: write data.
- `done` in 1: controller job-complete pulse.
- `job_done` out 1: one-cycle completion pulse to the host.
- `error` out 1: sticky protocol error; cleared by accepting the next command.

## Operation
- Constant N = INPUT_WIDTH*INPUT_HEIGHT.
- Operand counter `rd_cnt` and result counter `wr_cnt` both run 0..N-1, in row-major order (width innermost), matching the controller's index order.
- FSM states and transitions:
  - IDLE: `cmd_ready`=1. `cmd_valid` goes to START; this clears `rd_cnt`, `wr_cnt` and `error`.
  - START: `start`=1 for one cycle, then WAIT_REQ.
  - WAIT_REQ: if `done`, go to FINISH. Else if `input_req` and `rd_cnt`<N, go to FETCH. If `input_req` and `rd_cnt`==N, set `error` and stay in WAIT_REQ.
  - FETCH: `rd_en`=1, `rd_addr`=`rd_cnt`. Go to CAPTURE.
  - CAPTURE: `operand` <= `rd_data`, `rd_cnt`++. Go to PRESENT.
  - PRESENT: `input_ready`=1. Go to WAIT_REQ.
  - FINISH: `job_done`=1. If `wr_cnt`!=N, set `error`. Go to IDLE.
- Abort: if `input_req` drops while in FETCH or CAPTURE, return to WAIT_REQ. If it drops in CAPTURE, the capture still happens and `rd_cnt` still increments; otherwise `rd_cnt` is not incremented. No `input_ready` is issued.
- Result path runs independently of the FSM, in every state except IDLE:
  - `output_valid` is registered with `partial_sum`.
  - The next cycle drives `wr_en`=1, `wr_addr`=`wr_cnt`, `wr_data`=captured sum, then `wr_cnt`++.
  - `output_valid` with `wr_cnt`==N: the write is dropped and `error` is set.
  - `output_valid` in IDLE is ignored.
- `done` seen in any state other than WAIT_REQ: the FSM goes to FINISH after the current state.
- Counters do not wrap; they saturate at N.

## Timing
- Every output is registered. All outputs are 0 on reset, including `operand`, both counters and `cmd_ready`; `cmd_ready` becomes 1 in the first cycle after reset release.
- Command accept: `cmd_valid`&&`cmd_ready` at edge k gives `start`=1 in cycle k+1.
- Operand latency: `input_req` sampled high at edge n gives `rd_en` in cycle n+1, `operand` valid from n+3, and `input_ready` high in cycle n+3 only.
- `operand` remains stable at least until the next CAPTURE, which covers the controller's PE_init cycle.
- Result latency: `output_valid` at cycle m gives `wr_en` at cycle m+1.
- `job_done`: fires in the cycle after `done` is sampled in WAIT_REQ. Any result write still in flight completes in that same cycle, before IDLE.
- Asynchronous reset mid-job: everything clears immediately; the in-flight memory read is discarded.

## Structure
- Shared package `mvm_pkg`:
  - `feeder_state_t` enum: IDLE, START, WAIT_REQ, FETCH, CAPTURE, PRESENT, FINISH.
  - `N` and `ADDR_WIDTH` localparam functions.
  - `DATA_WIDTH`/`SUM_WIDTH` defaults.
- Sub-module `mvm_result_capture`: output_valid register, `wr_cnt`, overflow error and write port.
- The top level holds the FSM, `rd_cnt` and the operand register.

## Test plan
- 2x2 job, memory {3,5,7,9}, controller model returning sums {10,20,30,40}: four `input_ready` pulses with operand 3,5,7,9; writes to addr 0..3 with 10..40; one `job_done`; `error`=0.
- `cmd_valid` held high through a full job: exactly one `start` per job; `cmd_ready`=0 from START through FINISH; second job starts at `rd_cnt`=0.
- `input_req` 3 cycles after START: `rd_en` at +1, `input_ready` at +3; `operand` unchanged until the next request.
- `input_req` dropped during FETCH: no `input_ready`, `rd_cnt` unchanged; the next request re-reads the same address.
- A fifth `output_valid` on a 2x2 job: no `wr_en`, `error`=1; `done` after only 3 results gives `error`=1 with `job_done`.
- `reset` asserted low in CAPTURE: all outputs 0 immediately; after release, `cmd_ready`=1 and a new job runs cleanly.

Source files
------------

// File: rtl/mvm_pkg.sv
// Shared definitions for the MVM host-side input feeder.
//   - feeder_state_t : states of the feeder FSM
//   - calc_n         : number of operands / results per job (width * height)
//   - addr_width     : memory address width for a job of that size (min 1)
//   - cnt_width      : width of a counter that must also hold the value N
//   - DEFAULT_DATA_WIDTH / DEFAULT_SUM_WIDTH : operand and partial-sum widths
`ifndef INPUT_WIDTH
`define INPUT_WIDTH 2
`endif
`ifndef INPUT_HEIGHT
`define INPUT_HEIGHT 2
`endif

package mvm_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_SUM_WIDTH  = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_REQ,
    FETCH,
    CAPTURE,
    PRESENT,
    FINISH
  } feeder_state_t;

  function automatic int calc_n(input int w, input int h);
    return w * h;
  endfunction

  function automatic int addr_width(input int w, input int h);
    int n;
    n = w * h;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Counters saturate at N, so they need one more code than the address range.
  function automatic int cnt_width(input int w, input int h);
    return $clog2(w * h + 1);
  endfunction

endpackage

// File: rtl/mvm_result_capture.sv
// Result path of the MVM input feeder.
// Registers each accepted output_valid/partial_sum pair and presents it on the
// result-memory write port in the following cycle at address wr_cnt, then
// advances wr_cnt. Once wr_cnt has reached N further results are dropped and
// flagged through the overflow pulse.
// Ports:
//   clock, reset        : clock, asynchronous active-low reset
//   active              : feeder is in a job (results outside a job are ignored)
//   clear               : new job accepted, restart wr_cnt at 0
//   output_valid        : controller result strobe
//   partial_sum         : result accompanying output_valid
//   wr_en/wr_addr/wr_data : registered result-memory write port
//   wr_cnt_next         : result count as it will be after this edge
//   overflow            : result arrived with wr_cnt == N (combinational pulse)
module mvm_result_capture
  import mvm_pkg::*;
#(
  parameter int SUM_WIDTH  = DEFAULT_SUM_WIDTH,
  parameter int ADDR_WIDTH = 2,
  parameter int CNT_WIDTH  = 3,
  parameter int N          = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  active,
  input  logic                  clear,
  input  logic                  output_valid,
  input  logic [SUM_WIDTH-1:0]  partial_sum,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [SUM_WIDTH-1:0]  wr_data,
  output logic [CNT_WIDTH-1:0]  wr_cnt_next,
  output logic                  overflow
);

  localparam logic [CNT_WIDTH-1:0] N_CNT = CNT_WIDTH'(N);

  logic [CNT_WIDTH-1:0] wr_cnt;
  logic                 accept;
  logic                 full;
  logic                 do_write;

  always_comb begin
    accept      = active && output_valid;
    full        = (wr_cnt == N_CNT);
    do_write    = accept && !full;
    overflow    = accept && full;
    wr_cnt_next = wr_cnt;
    if (clear) begin
      wr_cnt_next = '0;
    end else if (do_write) begin
      wr_cnt_next = wr_cnt + CNT_WIDTH'(1);
    end
  end

  // The write-port flops double as the output_valid/partial_sum register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      wr_cnt  <= '0;
    end else begin
      wr_en  <= do_write;
      wr_cnt <= wr_cnt_next;
      if (do_write) begin
        wr_addr <= ADDR_WIDTH'(wr_cnt);
        wr_data <= partial_sum;
      end
    end
  end

endmodule

// File: rtl/mvm_input_feeder.sv
// Host-side feeder for the MVM controller.
// Accepts a job from the host, pulses start to the controller, answers each
// input_req with the next operand from operand memory (row-major order) and
// hands results to mvm_result_capture for writing into result memory. Job
// completion is reported with job_done; protocol problems set a sticky error.
//
// Handshakes:
//   cmd_valid/cmd_ready : a job is accepted on an edge where both are high;
//                         cmd_ready is high only while idle.
//   input_req/input_ready : controller holds input_req until it sees the
//                         single-cycle input_ready; operand is valid with it and
//                         stays put until the next capture. Dropping input_req
//                         before input_ready cancels the request.
//   rd_en/rd_data       : rd_data is valid exactly one cycle after rd_en.
//   output_valid/wr_en  : no back-pressure; each result is written one cycle later.
// Ports:
//   clock, reset : clock, asynchronous active-low reset
//   cmd_valid, cmd_ready, job_done, error : host side
//   start, input_req, input_ready, operand, output_valid, partial_sum, done : controller side
//   rd_en, rd_addr, rd_data : operand memory read port
//   wr_en, wr_addr, wr_data : result memory write port
//   dbg_state : current FSM state
module mvm_input_feeder
  import mvm_pkg::*;
#(
  parameter int INPUT_WIDTH  = `INPUT_WIDTH,
  parameter int INPUT_HEIGHT = `INPUT_HEIGHT,
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int SUM_WIDTH    = DEFAULT_SUM_WIDTH,
  parameter int ADDR_WIDTH   = addr_width(INPUT_WIDTH, INPUT_HEIGHT)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  output logic                  start,
  input  logic                  input_req,
  output logic                  input_ready,
  output logic [DATA_WIDTH-1:0] operand,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  output_valid,
  input  logic [SUM_WIDTH-1:0]  partial_sum,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [SUM_WIDTH-1:0]  wr_data,
  input  logic                  done,
  output logic                  job_done,
  output logic                  error,
  output feeder_state_t         dbg_state
);

  localparam int N         = calc_n(INPUT_WIDTH, INPUT_HEIGHT);
  localparam int CNT_WIDTH = cnt_width(INPUT_WIDTH, INPUT_HEIGHT);
  localparam logic [CNT_WIDTH-1:0] N_CNT = CNT_WIDTH'(N);

  feeder_state_t        state;
  feeder_state_t        state_next;
  logic [CNT_WIDTH-1:0] rd_cnt;
  logic [CNT_WIDTH-1:0] wr_cnt_next;
  logic                 rd_full;
  logic                 cmd_accept;
  logic                 overflow;
  logic                 req_err;
  logic                 fin_err;

  assign dbg_state = state;

  // Next state. A done pulse outside WAIT_REQ ends the job right after the
  // current (single-cycle) state; done while idle is not a job and is ignored.
  always_comb begin
    state_next = state;
    rd_full    = (rd_cnt == N_CNT);
    cmd_accept = (state == IDLE) && cmd_valid && cmd_ready;
    unique case (state)
      IDLE:     if (cmd_accept) state_next = START;
      START:    state_next = done ? FINISH : WAIT_REQ;
      WAIT_REQ: begin
        if (done)                       state_next = FINISH;
        else if (input_req && !rd_full) state_next = FETCH;
      end
      FETCH: begin
        if (done)            state_next = FINISH;
        else if (!input_req) state_next = WAIT_REQ;
        else                 state_next = CAPTURE;
      end
      CAPTURE: begin
        if (done)            state_next = FINISH;
        else if (!input_req) state_next = WAIT_REQ;
        else                 state_next = PRESENT;
      end
      PRESENT:  state_next = done ? FINISH : WAIT_REQ;
      FINISH:   state_next = IDLE;
      default:  state_next = IDLE;
    endcase
    req_err = (state == WAIT_REQ) && !done && input_req && rd_full;
    // Judge the result count as it will stand in FINISH so a write landing in
    // that same cycle counts and error lines up with job_done.
    fin_err = (state_next == FINISH) && (wr_cnt_next != N_CNT);
  end

  // State register plus outputs decoded from the next state, so every
  // strobe is a flop that is high exactly while the FSM sits in that state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cmd_ready   <= 1'b0;
      start       <= 1'b0;
      rd_en       <= 1'b0;
      rd_addr     <= '0;
      input_ready <= 1'b0;
      job_done    <= 1'b0;
    end else begin
      state       <= state_next;
      cmd_ready   <= (state_next == IDLE);
      start       <= (state_next == START);
      rd_en       <= (state_next == FETCH);
      input_ready <= (state_next == PRESENT);
      job_done    <= (state_next == FINISH);
      if (state_next == FETCH) begin
        rd_addr <= ADDR_WIDTH'(rd_cnt);
      end
    end
  end

  // Operand register and read counter. A capture always completes, even when
  // the request is withdrawn during CAPTURE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_cnt  <= '0;
      operand <= '0;
    end else begin
      if (cmd_accept) begin
        rd_cnt <= '0;
      end else if (state == CAPTURE && !rd_full) begin
        rd_cnt <= rd_cnt + CNT_WIDTH'(1);
      end
      if (state == CAPTURE) begin
        operand <= rd_data;
      end
    end
  end

  // Sticky error, cleared only by accepting the next job.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      error <= 1'b0;
    end else if (cmd_accept) begin
      error <= 1'b0;
    end else if (overflow || req_err || fin_err) begin
      error <= 1'b1;
    end
  end

  mvm_result_capture #(
    .SUM_WIDTH  (SUM_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH),
    .N          (N)
  ) u_result_capture (
    .clock        (clock),
    .reset        (reset),
    .active       (state != IDLE),
    .clear        (cmd_accept),
    .output_valid (output_valid),
    .partial_sum  (partial_sum),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_cnt_next  (wr_cnt_next),
    .overflow     (overflow)
  );

endmodule
